// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: LFSR-driven one-hot LED draw plus a millisecond hit-window countdown.
// Build option: define MOLE_NO_REPEAT_EN to forbid the same LED on two consecutive moles.
//
// state   | meaning
// S_IDLE  | waiting for the first mole request after reset
// S_DRAW  | scanning LFSR candidates until one is accepted (or forced)
// S_READY | one-cycle rng_ready pulse, led_number/timeout valid
// S_RUN   | hit window counting down while timeout_start is high
module mole_spawner #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready_for_mole,
  input  logic        timeout_start,
  input  logic [2:0]  level_select,
  output logic        rng_ready,
  output logic [17:0] led_number,
  output logic [15:0] timeout
);

  localparam int unsigned DIV     = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
  localparam int          PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [4:0]  NUM_LEDS = 5'd18;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_READY, S_RUN} state_t;

  state_t          state, state_nxt;
  logic [15:0]     lfsr;
  logic [PW-1:0]   prescaler;
  logic [5:0]      rej_cnt;
  logic [4:0]      prev_idx;
  logic            prev_valid;
  logic [4:0]      cand, fallback, idx;
  logic            reject, forced, accept, count_en;
  logic [15:0]     window;

  assign cand     = lfsr[4:0];
  assign forced   = rej_cnt[5];
  assign fallback = (!prev_valid || prev_idx == NUM_LEDS - 5'd1) ? 5'd0 : prev_idx + 5'd1;
  assign idx      = forced ? fallback : cand;

`ifdef MOLE_NO_REPEAT_EN
  assign reject = (cand >= NUM_LEDS) || (prev_valid && cand == prev_idx);
`else
  assign reject = (cand >= NUM_LEDS);
`endif

  always_comb begin
    window = 16'd2000;
    case (level_select)
      3'b001:  window = 16'd1500;
      3'b010:  window = 16'd1000;
      3'b100:  window = 16'd600;
      default: window = 16'd2000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    count_en  = 1'b0;
    case (state)
      S_IDLE:  if (ready_for_mole) state_nxt = S_DRAW;
      S_DRAW: begin
        if (forced || !reject) begin
          accept    = 1'b1;
          state_nxt = S_READY;
        end
      end
      S_READY: state_nxt = S_RUN;
      S_RUN: begin
        // A new request wins over a tick landing in the same cycle.
        if (ready_for_mole) state_nxt = S_DRAW;
        else if (timeout_start && timeout != 16'd0) count_en = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr       <= SEED;
      rej_cnt    <= 6'd0;
      prescaler  <= '0;
      led_number <= 18'd0;
      timeout    <= 16'd0;
      prev_idx   <= 5'd0;
      prev_valid <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (state == S_DRAW && !accept) rej_cnt <= rej_cnt + 6'd1;
      else                            rej_cnt <= 6'd0;

      if (accept) begin
        led_number <= 18'(1) << idx;
        prev_idx   <= idx;
        prev_valid <= 1'b1;
        timeout    <= window;
        prescaler  <= '0;
      end else if (count_en) begin
        if (prescaler == PRE_MAX) begin
          prescaler <= '0;
          timeout   <= timeout - 16'd1;
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

  assign rng_ready = (state == S_READY);

endmodule

// File: doc/mole_spawner.md
MOLE_SPAWNER -- requirements
Module: mole_spawner

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, countdown tick rate in Hz; one tick = 1 ms.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-004 clk  input  1  system clock; all flops rising-edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ready_for_mole  input  1  game FSM request for a new mole (level).
REQ-007 timeout_start  input  1  countdown enable while high (level).
REQ-008 level_select  input  3  one-hot difficulty (000, 001, 010, 100).
REQ-009 rng_ready  output  1  one-cycle pulse: led_number and timeout are valid.
REQ-010 led_number  output  18  one-hot mole LED.
REQ-011 timeout  output  16  remaining hit window in ms.

Function
REQ-012 The block SHALL have states S_IDLE, S_DRAW, S_READY and S_RUN; outputs SHALL be decoded from registered state and registers only.
REQ-013 The 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every clock in every state.
REQ-014 S_IDLE: rng_ready=0; ready_for_mole=1 -> S_DRAW.
REQ-015 S_DRAW: candidate idx = lfsr[4:0]; idx<18 accepts, idx>=18 rejects and retries next cycle.
REQ-016 After 32 consecutive rejects in one draw, idx SHALL be forced to (prev_idx+1) mod 18, or 0 if there is no prev_idx; draw latency is bounded to 33 cycles.
REQ-017 On accept: led_number <= 1<<idx; prev_idx <= idx; timeout <= window(level_select sampled that cycle); prescaler <= 0; go to S_READY.
REQ-018 window(): 000->2000, 001->1500, 010->1000, 100->600; any other code -> 2000.
REQ-019 S_READY: rng_ready=1 for exactly one cycle -> S_RUN unconditionally.
REQ-020 Minimum latency SHALL be ready_for_mole sampled high at edge N -> rng_ready high in cycle N+2.
REQ-021 S_RUN: while timeout_start=1 and timeout>0, the prescaler SHALL count 0..CLK_HZ/TICK_HZ-1; on wrap, timeout decrements by 1.
REQ-022 timeout SHALL saturate at 0 and never wrap; the prescaler SHALL hold while timeout=0 or timeout_start=0 (pause, no clear).
REQ-023 S_RUN: ready_for_mole=1 -> S_DRAW; this SHALL take priority over decrement in the same cycle.
REQ-024 S_RUN with both inputs low SHALL hold all outputs (game aborted or between moles).
REQ-025 led_number SHALL hold its last mole until the next accept and SHALL never have more than one bit set.
REQ-026 level_select changes SHALL affect only the next accept, never a running window.
REQ-027 Prescaler width SHALL be $clog2(CLK_HZ/TICK_HZ), minimum 1.

Reset
REQ-028 reset_n low SHALL immediately force: state=S_IDLE, rng_ready=0, led_number=0, timeout=0, prescaler=0, reject count=0, lfsr=LFSR_SEED, prev_idx=none.
REQ-029 Reset mid-draw or mid-countdown SHALL discard the mole; the first request after release SHALL start a fresh draw.
REQ-030 Reset release SHALL take effect on the first rising clk edge with reset_n high.

Configuration
REQ-031 Macro MOLE_NO_REPEAT_EN defined: a candidate equal to prev_idx SHALL also be rejected (counted toward the 32-reject limit); the forced fallback already differs from prev_idx.
REQ-032 Macro MOLE_NO_REPEAT_EN undefined: consecutive moles MAY repeat the same LED; no prev_idx comparison logic is built.

Verification (CLK_HZ=10_000, TICK_HZ=1000 -> tick every 10 clocks)
REQ-033 Reset, then ready_for_mole=1 at edge 0, level_select=010 -> rng_ready pulse no earlier than cycle 2, exactly 1 cycle wide; timeout=1000; led_number one-hot, index <18.
REQ-034 timeout_start held high after the pulse -> timeout=999 after 10 clocks; reaches 0 after 10_000 clocks; stays 0 for a further 100 clocks.
REQ-035 timeout_start low for 25 clocks at timeout=700, then high -> value stays 700 during the pause; the decrement resumes with no lost prescaler count.
REQ-036 1000 back-to-back draws with MOLE_NO_REPEAT_EN defined -> no two consecutive equal led_number; every rng_ready latency <=33 cycles; all 18 LEDs seen.
REQ-037 level_select=100, 001, 111 on three successive draws -> timeout loads 600, 1500, 2000.
REQ-038 reset_n pulsed low mid-countdown (timeout=400) -> outputs 0 asynchronously; the next request yields a fresh draw with the full window.
